// File: rtl/seg_digit_scan_if.sv
// Scan-controller bus: BCD load port plus decoder/digit-drive outputs.
// The master side loads digits and observes the scan outputs.
interface seg_digit_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                load;
  logic [3:0]          data;
  logic [DIGITS-1:0]   digit_sel;
  logic                scan_tick;

  modport master (
    output bcd_in, load,
    input  data, digit_sel, scan_tick
  );

  modport slave (
    input  bcd_in, load,
    output data, digit_sel, scan_tick
  );
endinterface

// File: rtl/seg_digit_scan.sv
// Multiplexed 7-seg scan controller feeding one registered decoder.
// SEG_BLANK_LEADING_EN enables leading-zero digit suppression.
module seg_digit_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  seg_digit_scan_if.slave  bus
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0]       presc;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow;
  logic [3:0]          data_q;
  logic [DIGITS-1:0]   sel_d;
  logic [DIGITS-1:0]   sel_q;
  logic                tick_q;
  logic                last;
  logic [3:0]          cur;
  logic [DIGITS-1:0]   onehot;

  assign last = (presc == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc  <= '0;
      idx    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= last;
      if (last) begin
        presc <= '0;
        if (idx == IDX_W'(DIGITS - 1))
          idx <= '0;
        else
          idx <= idx + IDX_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      shadow <= '0;
    else if (bus.load)
      shadow <= bus.bcd_in;
  end

  always_comb begin
    cur    = 4'd0;
    onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur       = shadow[4*k +: 4];
        onehot[k] = 1'b1;
      end
    end
  end

`ifdef SEG_BLANK_LEADING_EN
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] blank_d;
  logic              zrun;

  // Walk down from the top digit; digit 0 is never blanked
  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zrun     = zrun & (shadow[4*k +: 4] == 4'd0);
      blank[k] = zrun;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= 4'd0;
      sel_d   <= '0;
      blank_d <= '0;
      sel_q   <= '0;
    end else begin
      data_q  <= cur;
      sel_d   <= onehot;
      blank_d <= blank;
      sel_q   <= sel_d & ~blank_d;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= 4'd0;
      sel_d  <= '0;
      sel_q  <= '0;
    end else begin
      data_q <= cur;
      sel_d  <= onehot;
      sel_q  <= sel_d;
    end
  end
`endif

  assign bus.data      = data_q;
  assign bus.digit_sel = sel_q;
  assign bus.scan_tick = tick_q;

endmodule

// File: tb/tb_seg_digit_scan.sv
// Directed bench for seg_digit_scan, DIGITS=4 DIV=4.
// Expected vectors adapt to SEG_BLANK_LEADING_EN.
module tb_seg_digit_scan;

`ifdef SEG_BLANK_LEADING_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [3:0] B2 = BLANK ? 4'h0 : 4'h2;
  localparam logic [3:0] B4 = BLANK ? 4'h0 : 4'h4;
  localparam logic [3:0] B8 = BLANK ? 4'h0 : 4'h8;

  logic  clk;
  logic  reset;
  int    n_chk;
  int    n_err;
  int    cyc;
  string ph;

  seg_digit_scan_if #(.DIGITS(4)) bus ();

  seg_digit_scan #(
    .DIGITS(4),
    .DIV   (4),
    .IDX_W (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data"}, 16'(bus.data), 16'h0);
    chk({tag, ".sel"}, 16'(bus.digit_sel), 16'h0);
    chk({tag, ".tick"}, 16'(bus.scan_tick), 16'h0);
  endtask

  // Drive one edge's inputs, clock it, check the registered outputs
  task automatic vec(input logic ld, input logic [15:0] b,
                     input logic [3:0] ed, input logic [3:0] es,
                     input logic et);
    bus.load   = ld;
    bus.bcd_in = b;
    @(posedge clk);
    #1;
    cyc++;
    chk($sformatf("%s.e%0d.data", ph, cyc), 16'(bus.data), 16'(ed));
    chk($sformatf("%s.e%0d.sel", ph, cyc), 16'(bus.digit_sel), 16'(es));
    chk($sformatf("%s.e%0d.tick", ph, cyc), 16'(bus.scan_tick), 16'(et));
    bus.load = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    cyc        = 0;
    reset      = 1'b0;
    bus.load   = 1'b0;
    bus.bcd_in = 16'h0;

    ph = "rst";
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");

    // Scan 1234 through wrap-around, then a mid-slot load
    release_rst();
    ph = "scan";
    vec(1, 16'h1234, 4'h0, 4'h0, 0);
    vec(0, 16'h0,    4'h4, 4'h1, 0);
    vec(0, 16'h0,    4'h4, 4'h1, 0);
    vec(0, 16'h0,    4'h4, 4'h1, 1);
    vec(0, 16'h0,    4'h3, 4'h1, 0);
    vec(0, 16'h0,    4'h3, 4'h2, 0);
    vec(0, 16'h0,    4'h3, 4'h2, 0);
    vec(0, 16'h0,    4'h3, 4'h2, 1);
    vec(0, 16'h0,    4'h2, 4'h2, 0);
    vec(0, 16'h0,    4'h2, 4'h4, 0);
    vec(0, 16'h0,    4'h2, 4'h4, 0);
    vec(0, 16'h0,    4'h2, 4'h4, 1);
    vec(0, 16'h0,    4'h1, 4'h4, 0);
    vec(0, 16'h0,    4'h1, 4'h8, 0);
    vec(0, 16'h0,    4'h1, 4'h8, 0);
    vec(0, 16'h0,    4'h1, 4'h8, 1);
    vec(0, 16'h0,    4'h4, 4'h8, 0);
    vec(0, 16'h0,    4'h4, 4'h1, 0);
    vec(0, 16'h0,    4'h4, 4'h1, 0);
    vec(0, 16'h0,    4'h4, 4'h1, 1);
    vec(0, 16'h0,    4'h3, 4'h1, 0);
    ph = "midload";
    vec(1, 16'h9876, 4'h3, 4'h2, 0);
    vec(0, 16'h0,    4'h7, 4'h2, 0);
    vec(0, 16'h0,    4'h7, 4'h2, 1);
    vec(0, 16'h0,    4'h8, 4'h2, 0);

    // Async reset in slot 2, cycle 2
    reset = 1'b0;
    #2;
    chk_zero("midrst");

    // Restart: full first slot, codes above 9 passed through
    release_rst();
    ph = "a5";
    vec(1, 16'h00A5, 4'h0, 4'h0, 0);
    vec(0, 16'h0,    4'h5, 4'h1, 0);
    vec(0, 16'h0,    4'h5, 4'h1, 0);
    vec(0, 16'h0,    4'h5, 4'h1, 1);
    vec(0, 16'h0,    4'hA, 4'h1, 0);
    vec(0, 16'h0,    4'hA, 4'h2, 0);
    vec(0, 16'h0,    4'hA, 4'h2, 0);
    vec(0, 16'h0,    4'hA, 4'h2, 1);
    vec(0, 16'h0,    4'h0, 4'h2, 0);
    vec(0, 16'h0,    4'h0, B4,   0);
    vec(0, 16'h0,    4'h0, B4,   0);
    vec(0, 16'h0,    4'h0, B4,   1);
    vec(0, 16'h0,    4'h0, B4,   0);
    vec(0, 16'h0,    4'h0, B8,   0);
    vec(0, 16'h0,    4'h0, B8,   0);
    vec(0, 16'h0,    4'h0, B8,   1);
    vec(0, 16'h0,    4'h5, B8,   0);
    vec(0, 16'h0,    4'h5, 4'h1, 0);

    // Single significant digit, then all zero
    reset = 1'b0;
    release_rst();
    ph = "d5";
    vec(1, 16'h0005, 4'h0, 4'h0, 0);
    vec(0, 16'h0,    4'h5, 4'h1, 0);
    vec(0, 16'h0,    4'h5, 4'h1, 0);
    vec(0, 16'h0,    4'h5, 4'h1, 1);
    vec(0, 16'h0,    4'h0, 4'h1, 0);
    vec(0, 16'h0,    4'h0, B2,   0);
    vec(0, 16'h0,    4'h0, B2,   0);
    vec(0, 16'h0,    4'h0, B2,   1);
    vec(0, 16'h0,    4'h0, B2,   0);
    vec(0, 16'h0,    4'h0, B4,   0);
    vec(0, 16'h0,    4'h0, B4,   0);
    vec(0, 16'h0,    4'h0, B4,   1);
    vec(0, 16'h0,    4'h0, B4,   0);
    vec(0, 16'h0,    4'h0, B8,   0);
    vec(0, 16'h0,    4'h0, B8,   0);
    vec(0, 16'h0,    4'h0, B8,   1);
    vec(0, 16'h0,    4'h5, B8,   0);
    vec(0, 16'h0,    4'h5, 4'h1, 0);
    ph = "d0";
    vec(1, 16'h0000, 4'h5, 4'h1, 0);
    vec(0, 16'h0,    4'h0, 4'h1, 1);
    vec(0, 16'h0,    4'h0, 4'h1, 0);
    vec(0, 16'h0,    4'h0, B2,   0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
